vga_sync_receiver: RTL

- Receiving end of the VGA timing interface: takes sync and 4-bit RGB signals as the VGA generator drives them and recovers frame timing.
- Locks to the expected 640x480@60 timing, reports pixel position and visible area, and re-emits pixel data with a valid qualifier.
- Sits in the pixel clock domain.
- Used as loopback checker for the generator and as front end for future capture and scaler blocks.

---
 rtl/vga_sync_receiver_if.sv | 14 +
 rtl/vga_sync_receiver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver_if.sv
// vga_sync_receiver_if: VGA sync and colour lines as driven by a VGA source
interface vga_sync_receiver_if;
  logic       in_vga_horizontal_sync;
  logic       in_vga_vertical_sync;
  logic [3:0] in_vga_r;
  logic [3:0] in_vga_g;
  logic [3:0] in_vga_b;
  modport master (
    output in_vga_horizontal_sync, in_vga_vertical_sync, in_vga_r, in_vga_g, in_vga_b
  );
  modport slave (
    input in_vga_horizontal_sync, in_vga_vertical_sync, in_vga_r, in_vga_g, in_vga_b
  );
endinterface

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers 640x480@60 VGA timing, locks to it and re-emits qualified pixels; VGA_RX_CHECKSUM_EN adds a per-frame pixel checksum
module vga_sync_receiver #(
  parameter int H_VISIBLE       = 640,
  parameter int H_SYNC          = 96,
  parameter int H_BACK_PORCH    = 48,
  parameter int H_TOTAL         = 800,
  parameter int V_VISIBLE       = 480,
  parameter int V_SYNC          = 2,
  parameter int V_BACK_PORCH    = 33,
  parameter int V_TOTAL         = 525,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic               clk_pixel,
  input  logic               reset_n,
  vga_sync_receiver_if.slave vga,
  output logic [3:0]         out_vga_r,
  output logic [3:0]         out_vga_g,
  output logic [3:0]         out_vga_b,
  output logic [9:0]         out_h_position,
  output logic [9:0]         out_v_position,
  output logic               out_visible_area,
  output logic               out_pixel_valid,
  output logic               out_locked,
  output logic               out_error,
  output logic [15:0]        out_frame_checksum
);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  localparam logic        POL     = SYNC_ACTIVE_LOW != 0;
  localparam logic [10:0] H_START = 11'(H_SYNC + H_BACK_PORCH);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BACK_PORCH + H_VISIBLE);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BACK_PORCH);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BACK_PORCH + V_VISIBLE);
  localparam logic [11:0] H_LEN   = 12'(H_TOTAL);
  localparam logic [10:0] V_LEN   = 11'(V_TOTAL);
  localparam logic [2:0]  LOCK_N  = 3'(LOCK_FRAMES);

  state_t      state_q, state_d;
  logic        hs1_q, hs1_d, vs1_q, vs1_d, hs0_q, hs0_d, vs0_q, vs0_d;
  logic [3:0]  r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
  logic [10:0] h_count_q, h_count_d;
  logic [9:0]  v_count_q, v_count_d;
  logic        armed_q, armed_d, line_bad_q, line_bad_d;
  logic [2:0]  good_q, good_d;
  logic [3:0]  out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;
  logic [9:0]  out_h_q, out_h_d, out_v_q, out_v_d;
  logic        out_vis_q, out_vis_d, out_valid_q, out_valid_d;
  logic        out_locked_q, out_locked_d, out_error_q, out_error_d;
  logic        hs_edge, vs_edge, armed_now, v_reset, checking;
  logic        line_mis, frame_mis, sat_hit, frame_clean;
  logic        locked, fault, visible, valid;

  // Stage 1 capture, sync edge detection, line/frame counters and timing checks
  always_comb begin
    hs1_d       = vga.in_vga_horizontal_sync ^ POL;
    vs1_d       = vga.in_vga_vertical_sync ^ POL;
    r1_d        = vga.in_vga_r;
    g1_d        = vga.in_vga_g;
    b1_d        = vga.in_vga_b;
    hs0_d       = hs1_q;
    vs0_d       = vs1_q;
    hs_edge     = hs1_q & ~hs0_q;
    vs_edge     = vs1_q & ~vs0_q;
    armed_now   = armed_q | vs_edge;
    v_reset     = hs_edge & armed_now;
    armed_d     = armed_now & ~v_reset;
    h_count_d   = hs_edge ? '0 : &h_count_q ? h_count_q : h_count_q + 11'd1;
    v_count_d   = v_reset ? '0 : (hs_edge & ~&v_count_q) ? v_count_q + 10'd1 : v_count_q;
    checking    = state_q != SEARCH;
    line_mis    = checking & hs_edge & ({1'b0, h_count_q} + 12'd1 != H_LEN);
    frame_mis   = checking & v_reset & ({1'b0, v_count_q} + 11'd1 != V_LEN);
    sat_hit     = (&h_count_d) & (h_count_q == 11'd2046);
    line_bad_d  = ~v_reset & (line_bad_q | line_mis);
    frame_clean = ~(line_bad_q | line_mis | frame_mis);
    locked      = state_q == LOCKED;
    fault       = locked & (line_mis | frame_mis | sat_hit);
    visible     = (h_count_d >= H_START) & (h_count_d < H_END) &
                  (v_count_d >= V_START) & (v_count_d < V_END);
    valid       = visible & locked;
  end

  // Lock tracking: count clean frames up to lock, drop back on any mismatch
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SEARCH: if (v_reset) begin
        state_d = MEASURE;
        good_d  = '0;
      end
      MEASURE: if (sat_hit) state_d = SEARCH;
      else if (v_reset) begin
        good_d  = frame_clean ? good_q + 3'd1 : '0;
        state_d = (frame_clean && good_q + 3'd1 == LOCK_N) ? LOCKED : MEASURE;
      end
      LOCKED: if (fault) begin
        state_d = MEASURE;
        good_d  = '0;
      end
      default: state_d = SEARCH;
    endcase
  end

  // Stage 2 outputs; lock affects samples after the one that decides it
  always_comb begin
    out_r_d      = valid ? r1_q : '0;
    out_g_d      = valid ? g1_q : '0;
    out_b_d      = valid ? b1_q : '0;
    out_h_d      = visible ? 10'(h_count_d - H_START) : '0;
    out_v_d      = visible ? v_count_d - V_START : '0;
    out_vis_d    = visible;
    out_valid_d  = valid;
    out_locked_d = locked;
    out_error_d  = fault;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      state_q      <= SEARCH;
      hs1_q        <= 1'b0;
      vs1_q        <= 1'b0;
      hs0_q        <= 1'b0;
      vs0_q        <= 1'b0;
      r1_q         <= '0;
      g1_q         <= '0;
      b1_q         <= '0;
      h_count_q    <= '0;
      v_count_q    <= '0;
      armed_q      <= 1'b0;
      line_bad_q   <= 1'b0;
      good_q       <= '0;
      out_r_q      <= '0;
      out_g_q      <= '0;
      out_b_q      <= '0;
      out_h_q      <= '0;
      out_v_q      <= '0;
      out_vis_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_locked_q <= 1'b0;
      out_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hs1_q        <= hs1_d;
      vs1_q        <= vs1_d;
      hs0_q        <= hs0_d;
      vs0_q        <= vs0_d;
      r1_q         <= r1_d;
      g1_q         <= g1_d;
      b1_q         <= b1_d;
      h_count_q    <= h_count_d;
      v_count_q    <= v_count_d;
      armed_q      <= armed_d;
      line_bad_q   <= line_bad_d;
      good_q       <= good_d;
      out_r_q      <= out_r_d;
      out_g_q      <= out_g_d;
      out_b_q      <= out_b_d;
      out_h_q      <= out_h_d;
      out_v_q      <= out_v_d;
      out_vis_q    <= out_vis_d;
      out_valid_q  <= out_valid_d;
      out_locked_q <= out_locked_d;
      out_error_q  <= out_error_d;
    end
  end

  assign out_vga_r        = out_r_q;
  assign out_vga_g        = out_g_q;
  assign out_vga_b        = out_b_q;
  assign out_h_position   = out_h_q;
  assign out_v_position   = out_v_q;
  assign out_visible_area = out_vis_q;
  assign out_pixel_valid  = out_valid_q;
  assign out_locked       = out_locked_q;
  assign out_error        = out_error_q;

`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] acc_q, acc_d, cks_q, cks_d;

  // Sum each valid pixel; publish and restart at every locked frame boundary
  always_comb begin
    cks_d = (locked & v_reset) ? acc_q : cks_q;
    acc_d = (locked & (v_reset | fault)) ? '0 : valid ? acc_q + {4'd0, r1_q, g1_q, b1_q} : acc_q;
  end

  // Checksum registers
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      acc_q <= '0;
      cks_q <= '0;
    end else begin
      acc_q <= acc_d;
      cks_q <= cks_d;
    end
  end

  assign out_frame_checksum = cks_q;
`else
  assign out_frame_checksum = 16'd0;
`endif
endmodule
